// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - Hsiao SEC-DED column table, error classes and width helpers
package secded_pkg;

   localparam int MAX_CHK = 16;

   typedef enum logic [1:0] {NONE, SGL, DBL, UNC} err_e;

   // Fixed (32,7) data columns, index 31 down to 0
   localparam logic [31:0][6:0] H32 = {
      7'h34, 7'h4C, 7'h19, 7'h4A, 7'h29, 7'h49, 7'h32, 7'h2A,
      7'h1A, 7'h26, 7'h16, 7'h38, 7'h1C, 7'h0E, 7'h51, 7'h52,
      7'h54, 7'h58, 7'h61, 7'h62, 7'h64, 7'h68, 7'h70, 7'h45,
      7'h25, 7'h15, 7'h0D, 7'h43, 7'h23, 7'h13, 7'h0B, 7'h07
   };

   function automatic int cw_width(int data_w, int chk_w);
      return data_w + chk_w;
   endfunction

   function automatic int n_choose(int n, int k);
      int r;
      r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   function automatic int avail_cols(int chk_w);
      return n_choose(chk_w, 3) + n_choose(chk_w, 5);
   endfunction

   // Other geometries: weight-3 combinations in lexicographic order, then weight-5
   function automatic logic [MAX_CHK-1:0] h_col(int data_w, int chk_w, int idx);
      logic [MAX_CHK-1:0] col;
      int n;
      col = '0;
      n   = 0;
      if (data_w == 32 && chk_w == 7) begin
         col = MAX_CHK'(H32[idx]);
      end else begin
         for (int a = 0; a < chk_w; a++)
            for (int b = a + 1; b < chk_w; b++)
               for (int c = b + 1; c < chk_w; c++) begin
                  if (n == idx) begin
                     col = '0; col[a] = 1'b1; col[b] = 1'b1; col[c] = 1'b1;
                  end
                  n++;
               end
         for (int a = 0; a < chk_w; a++)
            for (int b = a + 1; b < chk_w; b++)
               for (int c = b + 1; c < chk_w; c++)
                  for (int d = c + 1; d < chk_w; d++)
                     for (int e = d + 1; e < chk_w; e++) begin
                        if (n == idx) begin
                           col = '0; col[a] = 1'b1; col[b] = 1'b1;
                           col[c] = 1'b1; col[d] = 1'b1; col[e] = 1'b1;
                        end
                        n++;
                     end
      end
      return col;
   endfunction

endpackage

// File: rtl/secded_dec_pipe_if.sv
// rtl/secded_dec_pipe_if.sv - codeword in / decoded word out stream bundle
interface secded_dec_pipe_if
   import secded_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7
);
   logic                                  in_valid;
   logic                                  in_ready;
   logic [cw_width(DATA_W, CHK_W)-1:0]    in;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [DATA_W-1:0]                     out;
   logic [CHK_W-1:0]                      syn;
   logic                                  sgl;
   logic                                  dbl;
   logic                                  unc;

   modport master (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out, syn, sgl, dbl, unc
   );

   modport slave (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out, syn, sgl, dbl, unc
   );
endinterface

// File: rtl/secded_syn.sv
// rtl/secded_syn.sv - combinational Hsiao syndrome; an encoder feeds zero check bits
module secded_syn
   import secded_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7
) (
   input  logic [cw_width(DATA_W, CHK_W)-1:0] cw,
   output logic [CHK_W-1:0]                   syn
);

   logic [CHK_W-1:0] term [DATA_W];

   for (genvar i = 0; i < DATA_W; i++) begin : g_term
      localparam logic [CHK_W-1:0] COL = CHK_W'(h_col(DATA_W, CHK_W, i));
      assign term[i] = cw[i] ? COL : '0;
   end

   always_comb begin
      syn = cw[DATA_W+CHK_W-1:DATA_W];
      for (int i = 0; i < DATA_W; i++) syn = syn ^ term[i];
   end

endmodule

// File: rtl/secded_dec_pipe.sv
// rtl/secded_dec_pipe.sv - two-stage SEC-DED decoder with valid/ready flow,
// saturating error counters and a sticky first-error syndrome log
module secded_dec_pipe
   import secded_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   secded_dec_pipe_if.slave  bus,
   input  logic              corr_en,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  sgl_cnt,
   output logic [CNT_W-1:0]  dbl_cnt,
   output logic [CHK_W-1:0]  first_syn,
   output logic              first_vld
);

   if (CHK_W > MAX_CHK || DATA_W > avail_cols(CHK_W)) begin : g_bad_cfg
      $error("secded_dec_pipe: not enough odd-weight columns for DATA_W/CHK_W");
   end

   logic [CHK_W-1:0]  in_syn;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [CHK_W-1:0]  s1_syn;
   logic              en1, en2, load2;
   logic [DATA_W-1:0] hit;
   logic [DATA_W-1:0] corr_data;
   err_e              cls;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_q;
   logic [CHK_W-1:0]  syn_q;
   logic              sgl_q, dbl_q, unc_q;

   secded_syn #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
      .cw  (bus.in),
      .syn (in_syn)
   );

   assign en2          = ~out_valid_q | bus.out_ready;
   assign en1          = ~s1_valid | en2;
   assign load2        = en2 & s1_valid;
   assign bus.in_ready = en1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
      end else if (en1) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_data <= bus.in[DATA_W-1:0];
            s1_syn  <= in_syn;
         end
      end
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_hit
      localparam logic [CHK_W-1:0] COL = CHK_W'(h_col(DATA_W, CHK_W, i));
      assign hit[i] = (s1_syn == COL);
   end

   // A single check-bit error has a unit-vector syndrome and leaves data alone
   always_comb begin
      cls = NONE;
      if (s1_syn == '0)
         cls = NONE;
      else if (^s1_syn == 1'b0)
         cls = DBL;
      else if ((|hit) || $onehot(s1_syn))
         cls = SGL;
      else
         cls = UNC;
      corr_data = s1_data ^ (corr_en ? hit : '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         syn_q       <= '0;
         sgl_q       <= 1'b0;
         dbl_q       <= 1'b0;
         unc_q       <= 1'b0;
      end else if (en2) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_q <= corr_data;
            syn_q <= s1_syn;
            sgl_q <= (cls == SGL);
            dbl_q <= (cls == DBL);
            unc_q <= (cls == UNC);
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.syn       = syn_q;
   assign bus.sgl       = sgl_q;
   assign bus.dbl       = dbl_q;
   assign bus.unc       = unc_q;

   // Clear takes priority over an event landing in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgl_cnt   <= '0;
         dbl_cnt   <= '0;
         first_syn <= '0;
         first_vld <= 1'b0;
      end else if (cnt_clr) begin
         sgl_cnt   <= '0;
         dbl_cnt   <= '0;
         first_syn <= '0;
         first_vld <= 1'b0;
      end else if (load2) begin
         if (cls == SGL && sgl_cnt != '1)
            sgl_cnt <= sgl_cnt + CNT_W'(1);
         if ((cls == DBL || cls == UNC) && dbl_cnt != '1)
            dbl_cnt <= dbl_cnt + CNT_W'(1);
         if (cls != NONE && !first_vld) begin
            first_syn <= s1_syn;
            first_vld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_secded_dec_pipe.sv
// tb/tb_secded_dec_pipe.sv - directed and randomised checks of secded_dec_pipe
// against an error-search reference model
module tb_secded_dec_pipe;

   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             corr_en = 1'b1;
   logic             cnt_clr = 1'b0;
   logic [CNT_W-1:0] sgl_cnt, dbl_cnt;
   logic [6:0]       first_syn;
   logic             first_vld;

   secded_dec_pipe_if #(.DATA_W(32), .CHK_W(7)) ifc ();

   secded_dec_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc),
      .corr_en   (corr_en),
      .cnt_clr   (cnt_clr),
      .sgl_cnt   (sgl_cnt),
      .dbl_cnt   (dbl_cnt),
      .first_syn (first_syn),
      .first_vld (first_vld)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   int hs [32][3] = '{
      '{0,1,2}, '{0,1,3}, '{0,1,4}, '{0,1,5}, '{0,1,6},
      '{0,2,3}, '{0,2,4}, '{0,2,5}, '{0,2,6},
      '{4,5,6}, '{3,5,6}, '{2,5,6}, '{1,5,6}, '{0,5,6},
      '{3,4,6}, '{2,4,6}, '{1,4,6}, '{0,4,6},
      '{1,2,3}, '{2,3,4}, '{3,4,5}, '{1,2,4}, '{1,2,5}, '{1,3,4}, '{1,3,5}, '{1,4,5},
      '{0,3,6}, '{0,3,5}, '{1,3,6}, '{0,3,4}, '{2,3,6}, '{2,4,5}
   };

   function automatic logic [6:0] bsyn(logic [38:0] cw);
      logic [6:0] s;
      s = cw[38:32];
      for (int i = 0; i < 32; i++)
         if (cw[i])
            for (int k = 0; k < 3; k++) s[hs[i][k]] = ~s[hs[i][k]];
      return s;
   endfunction

   function automatic logic [38:0] encode(logic [31:0] d);
      logic [38:0] c;
      c = {7'b0, d};
      c[38:32] = bsyn(c);
      return c;
   endfunction

   typedef struct {
      logic [31:0] d;
      logic [6:0]  s;
      logic        sg, db, un;
   } exp_t;

   // Single error = some one-bit flip makes the word consistent again
   function automatic exp_t model(logic [38:0] cw, logic corr);
      exp_t e;
      logic [38:0] t;
      int bi;
      bi = -1;
      e.s = bsyn(cw); e.d = cw[31:0]; e.sg = 0; e.db = 0; e.un = 0;
      if (e.s != 0) begin
         for (int b = 0; b < 39; b++) begin
            t = cw; t[b] = ~t[b];
            if (bsyn(t) == 0) bi = b;
         end
         if (bi >= 0) begin
            e.sg = 1;
            if (bi < 32 && corr) e.d[bi] = ~e.d[bi];
         end else if ($countones(e.s) % 2 == 0) e.db = 1;
         else e.un = 1;
      end
      return e;
   endfunction

   exp_t       q[$];
   int         m_sgl = 0, m_dbl = 0, n_out = 0;
   logic [6:0] m_fsyn = 0;
   logic       m_fvld = 0;
   bit         drop_next = 0;
   bit         done = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifc.out_valid) begin
         check("queue_nonempty", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q[0];
            check("out", ifc.out, e.d);
            check("syn", ifc.syn, e.s);
            check("flags", {ifc.sgl, ifc.dbl, ifc.unc}, {e.sg, e.db, e.un});
            if (ifc.out_ready) begin
               void'(q.pop_front());
               n_out++;
               if (drop_next) drop_next = 0;
               else begin
                  if (e.sg && m_sgl < CMAX) m_sgl++;
                  if ((e.db || e.un) && m_dbl < CMAX) m_dbl++;
                  if ((e.sg || e.db || e.un) && !m_fvld) begin
                     m_fvld = 1; m_fsyn = e.s;
                  end
               end
               check("sgl_cnt", sgl_cnt, m_sgl);
               check("dbl_cnt", dbl_cnt, m_dbl);
               check("first_vld", first_vld, m_fvld);
               check("first_syn", first_syn, m_fsyn);
            end
         end
      end
   end

   task automatic send(logic [38:0] w);
      int n;
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in = w;
      n = 0;
      while (!ifc.in_ready && n < 200) begin @(negedge clk); n++; end
      if (!ifc.in_ready) begin
         check("in_ready_timeout", 0, 1);
         ifc.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      q.push_back(model(w, corr_en));
      #1 ifc.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin @(posedge clk); n++; end
      check("drain", q.size(), 0);
   endtask

   task automatic dir(string name, logic [38:0] w, logic [31:0] eo, logic [6:0] es,
                      logic [2:0] ef, int esc, int edc, logic [6:0] efs, logic efv);
      int n;
      send(w);
      n = 0;
      @(negedge clk);
      while (!ifc.out_valid && n < 20) begin @(negedge clk); n++; end
      check({name, "_valid"}, ifc.out_valid, 1);
      check({name, "_out"}, ifc.out, eo);
      check({name, "_syn"}, ifc.syn, es);
      check({name, "_flags"}, {ifc.sgl, ifc.dbl, ifc.unc}, ef);
      check({name, "_sgl_cnt"}, sgl_cnt, esc);
      check({name, "_dbl_cnt"}, dbl_cnt, edc);
      check({name, "_first_syn"}, first_syn, efs);
      check({name, "_first_vld"}, first_vld, efv);
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, required finish before 500us");
      $fatal(1);
   end

   initial begin
      logic [38:0] ws [6];
      logic [38:0] w;
      int nf, idx, base;

      ifc.in_valid  = 1'b0;
      ifc.in        = '0;
      ifc.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", ifc.out_valid, 0);
      check("rst_out", ifc.out, 0);
      check("rst_syn", ifc.syn, 0);
      check("rst_flags", {ifc.sgl, ifc.dbl, ifc.unc}, 0);
      check("rst_cnts", {sgl_cnt, dbl_cnt}, 0);
      check("rst_log", {first_vld, first_syn}, 0);
      @(negedge clk);
      rst = 1'b0;

      dir("zero",   39'h0,          32'h0, 7'h00, 3'b000, 0, 0, 7'h00, 1'b0);
      dir("d0",     39'h1,          32'h0, 7'h07, 3'b100, 1, 0, 7'h07, 1'b1);
      corr_en = 1'b0;
      dir("d0_raw", 39'h1,          32'h1, 7'h07, 3'b100, 2, 0, 7'h07, 1'b1);
      corr_en = 1'b1;
      dir("c3",     39'h8_0000_0000, 32'h0, 7'h08, 3'b100, 3, 0, 7'h07, 1'b1);
      dir("d01",    39'h3,          32'h3, 7'h0C, 3'b010, 3, 1, 7'h07, 1'b1);
      dir("d012",   39'h7,          32'h7, 7'h1F, 3'b001, 3, 2, 7'h07, 1'b1);
      dir("sat4",   39'h20,         32'h0, 7'h0D, 3'b100, 3, 2, 7'h07, 1'b1);
      dir("sat5",   39'h10_0000,    32'h0, 7'h38, 3'b100, 3, 2, 7'h07, 1'b1);

      // Clear coinciding with a single-error word entering stage 2
      send(39'h200);
      cnt_clr = 1'b1;
      drop_next = 1; m_sgl = 0; m_dbl = 0; m_fvld = 0; m_fsyn = 0;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      @(negedge clk);
      check("clr_word_valid", ifc.out_valid, 1);
      check("clr_word_flags", {ifc.sgl, ifc.dbl, ifc.unc, ifc.syn}, {3'b100, 7'h70});
      check("clr_sgl_cnt", sgl_cnt, 0);
      check("clr_dbl_cnt", dbl_cnt, 0);
      check("clr_log", {first_vld, first_syn}, 0);
      drain();
      dir("post_clr", 39'h2, 32'h0, 7'h0B, 3'b100, 1, 0, 7'h0B, 1'b1);

      // Six-word burst against a four-cycle output stall
      ws[0] = encode(32'hDEADBEEF);
      ws[1] = encode(32'h12345678) ^ 39'h80;
      ws[2] = encode(32'h0) ^ 39'h3;
      ws[3] = encode(32'hFFFFFFFF);
      ws[4] = encode(32'hA5A5A5A5) ^ (39'h1 << 38);
      ws[5] = encode(32'h0F0F0F0F);
      base = n_out;
      @(posedge clk);
      #1 ifc.out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) send(ws[k]);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            check("stall_in_ready", ifc.in_ready, 0);
            check("stall_out_valid", ifc.out_valid, 1);
            repeat (2) @(posedge clk);
            #1 ifc.out_ready = 1'b1;
         end
      join
      drain();
      check("stream_count", n_out - base, 6);

      // Random words, 0-3 bit flips, random backpressure
      done = 0;
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               w = encode($urandom);
               nf = $urandom_range(0, 3);
               for (int j = 0; j < nf; j++) begin
                  idx = $urandom_range(0, 38);
                  w[idx] = ~w[idx];
               end
               send(w);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 ifc.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      ifc.out_ready = 1'b1;
      drain();
      corr_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         w = encode($urandom);
         w[k * 3] = ~w[k * 3];
         send(w);
      end
      drain();
      corr_en = 1'b1;

      // Reset with two words held in the pipe
      @(posedge clk);
      #1 ifc.out_ready = 1'b0;
      send(encode(32'h1111));
      send(encode(32'h2222) ^ 39'h1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", ifc.out_valid, 0);
      check("midrst_cnts", {sgl_cnt, dbl_cnt}, 0);
      check("midrst_log", {first_vld, first_syn}, 0);
      q.delete();
      m_sgl = 0; m_dbl = 0; m_fvld = 0; m_fsyn = 0; drop_next = 0;
      @(posedge clk);
      #1 check("midrst_out_valid_edge", ifc.out_valid, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      ifc.out_ready = 1'b1;
      dir("post_rst", encode(32'hCAFEF00D), 32'hCAFEF00D, 7'h00, 3'b000, 0, 0, 7'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
